// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU definitions: data/opcode widths, opcode encodings and the
// legality check used by the issue stage.
package alu_issue_stage_pkg;

    localparam int DATA_WIDTH           = 32;
    localparam int DATA_INDEX_LIMIT     = DATA_WIDTH - 1;
    localparam int ALU_OPRN_WIDTH       = 6;
    localparam int ALU_OPRN_INDEX_LIMIT = ALU_OPRN_WIDTH - 1;

    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_ADD = 6'h01;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SUB = 6'h02;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_MUL = 6'h03;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_AND = 6'h04;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_OR  = 6'h05;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_NOR = 6'h06;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SLT = 6'h07;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SHL = 6'h08;
    localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SHR = 6'h09;

    // Legal opcodes form the contiguous range add..shr.
    function automatic logic is_legal_oprn(input logic [ALU_OPRN_WIDTH-1:0] oprn);
        return (oprn >= ALU_OPRN_ADD) && (oprn <= ALU_OPRN_SHR);
    endfunction

endpackage

// File: rtl/alu_issue_stage_alu.sv
// Combinational ALU. Unknown opcodes yield zero so no X leaks downstream.
module alu_issue_stage_alu
    import alu_issue_stage_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]     op1,
    input  logic [DATA_WIDTH-1:0]     op2,
    input  logic [ALU_OPRN_WIDTH-1:0] oprn,
    output logic [DATA_WIDTH-1:0]     result
);

    logic shift_overflow;

    // Shift amount is the whole of op2; anything >= data width clears the result.
    assign shift_overflow = (op2 >= DATA_WIDTH);

    // Operation select.
    always_comb begin
        result = '0;
        case (oprn)
            ALU_OPRN_ADD: result = op1 + op2;
            ALU_OPRN_SUB: result = op1 - op2;
            ALU_OPRN_MUL: result = op1 * op2;
            ALU_OPRN_AND: result = op1 & op2;
            ALU_OPRN_OR:  result = op1 | op2;
            ALU_OPRN_NOR: result = ~(op1 | op2);
            ALU_OPRN_SLT: result = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
            ALU_OPRN_SHL: result = shift_overflow ? '0 : (op1 << op2[4:0]);
            ALU_OPRN_SHR: result = shift_overflow ? '0 : (op1 >> op2[4:0]);
            default:      result = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: evaluates an accepted command in its accept cycle and
// queues {result, tag, err} in a 2-entry FIFO for the downstream consumer.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_op1,
    input  logic [DATA_WIDTH-1:0]     in_op2,
    input  logic [ALU_OPRN_WIDTH-1:0] in_oprn,
    input  logic [3:0]                in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic [3:0]                out_tag,
    output logic                      out_err,
    output logic [15:0]               ops_done,
    output logic [7:0]                err_count
);

    localparam int FIFO_DEPTH = 2;
    localparam int TAG_WIDTH  = 4;

    logic [DATA_WIDTH-1:0] mem_result [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag    [FIFO_DEPTH];
    logic                  mem_err    [FIFO_DEPTH];

    logic                  head;
    logic                  tail;
    logic [1:0]            count;

    logic [DATA_WIDTH-1:0] alu_result;
    logic                  legal;
    logic                  accept;
    logic                  pop;

    alu_issue_stage_alu u_alu (
        .op1    (in_op1),
        .op2    (in_op2),
        .oprn   (in_oprn),
        .result (alu_result)
    );

    assign legal     = is_legal_oprn(in_oprn);

    // Ready looks only at registered occupancy, never at out_ready.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head entry is presented only while the FIFO holds something.
    always_comb begin
        out_result = '0;
        out_tag    = '0;
        out_err    = 1'b0;
        if (out_valid) begin
            out_result = mem_result[head];
            out_tag    = mem_tag[head];
            out_err    = mem_err[head];
        end
    end

    // FIFO storage: write the evaluated command at the tail on accept.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_result[i] <= '0;
                mem_tag[i]    <= '0;
                mem_err[i]    <= 1'b0;
            end
        end else if (accept) begin
            mem_result[tail] <= legal ? alu_result : '0;
            mem_tag[tail]    <= in_tag;
            mem_err[tail]    <= ~legal;
        end
    end

    // Pointers and occupancy; simultaneous accept and pop leaves count unchanged.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (accept) tail <= ~tail;
            if (pop)    head <= ~head;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Pop counter wraps; illegal-opcode counter saturates.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ops_done  <= '0;
            err_count <= '0;
        end else begin
            if (pop)
                ops_done <= ops_done + 16'd1;
            if (accept && !legal && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [5:0]  in_oprn;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_err;
    logic [15:0] ops_done;
    logic [7:0]  err_count;

    int vecs = 0;
    int miscompares = 0;
    int exp_ops = 0;

    alu_issue_stage dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .in_oprn    (in_oprn),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .ops_done   (ops_done),
        .err_count  (err_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op, input logic [3:0] t);
        in_valid = 1'b1;
        in_op1   = a;
        in_op2   = b;
        in_oprn  = op;
        in_tag   = t;
    endtask

    // Single transaction from an empty FIFO with out_ready=1; called just after a negedge.
    task automatic send_chk(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] op, input logic [3:0] t,
                            input logic [31:0] exp_res, input logic exp_err);
        out_ready = 1'b1;
        drive(a, b, op, t);
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_res"}, out_result, exp_res);
        chk({name, "_tag"}, {28'd0, out_tag}, {28'd0, t});
        chk({name, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        @(posedge CLK);
        exp_ops++;
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b0;
        in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_oprn = '0; in_tag = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_res", out_result, 32'd0);
        chk("rst_tag", {28'd0, out_tag}, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        chk("rst_ops", {16'd0, ops_done}, 32'd0);
        chk("rst_errcnt", {24'd0, err_count}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Basic add, then pop counted.
        send_chk("add", 32'd5, 32'd3, 6'h01, 4'd2, 32'd8, 1'b0);
        chk("ops_after_add", {16'd0, ops_done}, 32'd1);
        chk("empty_after_add", {31'd0, out_valid}, 32'd0);

        // Back-pressure: two accepted, third refused, order preserved.
        out_ready = 1'b0;
        drive(32'd10, 32'd4, 6'h02, 4'd3);
        @(posedge CLK); @(negedge CLK);
        drive(32'd7, 32'd6, 6'h03, 4'd4);
        chk("bp_head1", out_result, 32'd6);
        @(posedge CLK); @(negedge CLK);
        drive(32'hF0, 32'h3C, 6'h04, 4'd5);
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        @(posedge CLK); @(negedge CLK);
        chk("bp_still_full", {31'd0, in_ready}, 32'd0);
        chk("bp_stable_res", out_result, 32'd6);
        chk("bp_stable_tag", {28'd0, out_tag}, 32'd3);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK); exp_ops++; @(negedge CLK);
        chk("bp_head2", out_result, 32'd42);
        chk("bp_tag2", {28'd0, out_tag}, 32'd4);
        chk("bp_ready_freed", {31'd0, in_ready}, 32'd1);
        @(posedge CLK); exp_ops++; @(negedge CLK);
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        send_chk("and", 32'hF0, 32'h3C, 6'h04, 4'd5, 32'h30, 1'b0);

        // Shift / compare boundaries and remaining ops.
        send_chk("shl31", 32'd1, 32'd31, 6'h08, 4'd1, 32'h8000_0000, 1'b0);
        send_chk("shr40", 32'h8000_0000, 32'd40, 6'h09, 4'd2, 32'd0, 1'b0);
        send_chk("shl32", 32'd1, 32'd32, 6'h08, 4'd3, 32'd0, 1'b0);
        send_chk("slt_lo", 32'hFFFF_FFFF, 32'd1, 6'h07, 4'd4, 32'd0, 1'b0);
        send_chk("slt_hi", 32'd1, 32'hFFFF_FFFF, 6'h07, 4'd5, 32'd1, 1'b0);
        send_chk("or", 32'hF0, 32'h0F, 6'h05, 4'd6, 32'hFF, 1'b0);
        send_chk("nor", 32'd0, 32'd0, 6'h06, 4'd7, 32'hFFFF_FFFF, 1'b0);
        chk("ops_mid", {16'd0, ops_done}, exp_ops);

        // Illegal opcodes and saturation.
        send_chk("ill00", 32'd5, 32'd5, 6'h00, 4'd8, 32'd0, 1'b1);
        send_chk("ill3f", 32'd5, 32'd5, 6'h3F, 4'd9, 32'd0, 1'b1);
        chk("errcnt2", {24'd0, err_count}, 32'd2);
        out_ready = 1'b1;
        drive(32'd1, 32'd1, 6'h0A, 4'd0);
        repeat (300) @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        @(posedge CLK); @(negedge CLK);
        exp_ops += 300;
        chk("errcnt_sat", {24'd0, err_count}, 32'd255);
        chk("ops_after_ill", {16'd0, ops_done}, exp_ops);
        chk("ill_drained", {31'd0, out_valid}, 32'd0);

        // Simultaneous accept and pop at count=1.
        out_ready = 1'b0;
        drive(32'd1, 32'd1, 6'h01, 4'd6);
        @(posedge CLK); @(negedge CLK);
        drive(32'd9, 32'd2, 6'h02, 4'd7);
        out_ready = 1'b1;
        @(posedge CLK); exp_ops++; @(negedge CLK);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("sim_valid", {31'd0, out_valid}, 32'd1);
        chk("sim_res", out_result, 32'd7);
        chk("sim_tag", {28'd0, out_tag}, 32'd7);
        chk("sim_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        @(posedge CLK); exp_ops++; @(negedge CLK);
        chk("sim_empty", {31'd0, out_valid}, 32'd0);
        chk("ops_after_sim", {16'd0, ops_done}, exp_ops);

        // Mid-cycle reset with a full FIFO.
        out_ready = 1'b0;
        drive(32'd100, 32'd1, 6'h01, 4'd10);
        @(posedge CLK); @(negedge CLK);
        drive(32'd200, 32'd1, 6'h01, 4'd11);
        @(posedge CLK); @(negedge CLK);
        in_valid = 1'b0;
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2 RST = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_res", out_result, 32'd0);
        chk("mrst_ops", {16'd0, ops_done}, 32'd0);
        chk("mrst_errcnt", {24'd0, err_count}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); @(negedge CLK);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        send_chk("post_rst", 32'd3, 32'd4, 6'h03, 4'd12, 32'd12, 1'b0);
        chk("post_rst_ops", {16'd0, ops_done}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RST  input  1  asynchronous active-low reset.
REQ-003 in_valid  input  1  upstream command valid.
REQ-004 in_ready  output  1  stage can accept a command this cycle.
REQ-005 in_op1  input  32 (`DATA_WIDTH)  operand 1.
REQ-006 in_op2  input  32  operand 2.
REQ-007 in_oprn  input  6 (`ALU_OPRN_WIDTH)  ALU operation code.
REQ-008 in_tag  input  4  opaque command tag, returned with the result.
REQ-009 out_valid  output  1  result entry available.
REQ-010 out_ready  input  1  downstream accepts the result entry.
REQ-011 out_result  output  32  ALU result of the head entry.
REQ-012 out_tag  output  4  tag of the head entry.
REQ-013 out_err  output  1  head entry carried an illegal opcode.
REQ-014 ops_done  output  16  count of results popped; wraps modulo 2^16.
REQ-015 err_count  output  8  count of illegal opcodes accepted; saturates at 255.

Function
REQ-016 Accept occurs on a rising edge with in_valid=1 and in_ready=1; pop occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-017 Accepted command is evaluated in the accept cycle by the internal ALU; {result, tag, err} is written into a 2-entry FIFO at that edge.
REQ-018 Latency: a command accepted at edge N appears on out_* after edge N when the FIFO was empty; FIFO order is strictly preserved.
REQ-019 Legal opcodes are 0x01..0x09: add, sub, mul (low 32 bits), and, or, nor, slt (unsigned), shl, shr (shift amount = full op2; amount >= 32 gives 0).
REQ-020 Opcode 0x00 or >= 0x0A: entry stored with result=0 and err=1; never X.
REQ-021 in_ready = (count < 2); it depends only on registered count, with no combinational path from out_ready.
REQ-022 out_valid = (count > 0); out_result, out_tag and out_err are driven from the head entry and are 0 when count=0.
REQ-023 Simultaneous accept and pop at count=1: count stays 1; the new entry becomes head on the next cycle.
REQ-024 At count=2, in_ready=0; a pop at count=2 frees a slot, so in_ready=1 on the following cycle.
REQ-025 out_* and the head entry stay stable while out_valid=1 and out_ready=0.
REQ-026 ops_done increments by 1 per pop and wraps 0xFFFF->0x0000.
REQ-027 err_count increments by 1 per accept with an illegal opcode and holds at 0xFF.

Reset
REQ-028 RST=0 asynchronously clears count, FIFO pointers, FIFO contents, ops_done and err_count to 0.
REQ-029 During and after reset: out_valid=0, out_result=0, out_tag=0, out_err=0, in_ready=1.
REQ-030 Reset asserted mid-operation discards all queued entries; no partial entry survives reset.

Structure
REQ-031 `DATA_WIDTH, `DATA_INDEX_LIMIT, `ALU_OPRN_WIDTH, `ALU_OPRN_INDEX_LIMIT and the opcode constants live in the shared prj_definition.v; FIFO depth (2) and tag width (4) are local parameters.
REQ-032 The existing combinational alu module is instantiated once as the sole sub-module; the legality check and zero substitution are done in this block.
REQ-033 Target size is 120-400 lines of RTL: FIFO with count, head and tail pointers; two counters; and the accept/pop logic.

Verification
REQ-034 Reset, then accept op1=5, op2=3, oprn=0x01, tag=2 with out_ready=1 -> next cycle out_valid=1, out_result=8, out_tag=2, out_err=0; ops_done=1 after the pop.
REQ-035 Hold out_ready=0 and offer three commands (sub 10-4, mul 7*6, and 0xF0&0x3C) -> first two accepted, in_ready=0 on the third; then release -> results 6, 42, 0x30 in order.
REQ-036 oprn=0x00 and oprn=0x3F -> out_result=0, out_err=1; err_count=2. Then 300 illegal opcodes -> err_count=255.
REQ-037 count=1 with accept and pop on the same edge -> count stays 1, out_valid stays 1, and the head shows the new entry's result and tag.
REQ-038 shl with op1=1, op2=31 -> 0x80000000; shr with op1=0x80000000, op2=40 -> 0; slt with op1=0xFFFFFFFF, op2=1 -> 0.
REQ-039 Fill FIFO to 2, then pulse RST low mid-cycle -> out_valid=0 and in_ready=1 immediately; ops_done=0; no stale entry after release.
